// File: rtl/cache_bus_arbiter_if.sv
// FTA 256-bit command request type and the arbiter-facing bus bundle.
// Requesters drive the master modport; the arbiter sits on the slave modport.
package fta_bus_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;

    typedef struct packed {
        logic [5:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic          cyc;
        logic          we;
        logic [2:0]    cti;
        logic [3:0]    pri;
        fta_tranid_t   tid;
        logic [31:0]   sel;
        logic [31:0]   adr;
        logic [255:0]  dat;
    } fta_cmd_request256_t;
endpackage

interface cache_bus_arbiter_if #(parameter int NREQ = 4);
    import fta_bus_pkg::*;

    fta_cmd_request256_t req_i [NREQ];
    logic [NREQ-1:0]     lock_i;
    logic [NREQ-1:0]     full_o;
    logic [NREQ-1:0]     grant_o;
    fta_cmd_request256_t bus_req_o;
    logic                bus_full_i;
    logic                resp_ack_i;
    logic [5:0]          resp_cid_i;
    logic [NREQ-1:0]     ack_o;
    logic                bad_ack_o;

    modport slave (
        input  req_i, lock_i, bus_full_i, resp_ack_i, resp_cid_i,
        output full_o, grant_o, bus_req_o, ack_o, bad_ack_o
    );

    modport master (
        output req_i, lock_i, bus_full_i, resp_ack_i, resp_cid_i,
        input  full_o, grant_o, bus_req_o, ack_o, bad_ack_o
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter with lock window sharing one FTA request port between cache generators.
// Optional macro CACHE_BUS_ARB_PRI_EN: priority-first selection and early HOLD preemption.
module cache_bus_arbiter
    import fta_bus_pkg::*;
#(
    parameter int         NREQ     = 4,
    parameter logic [5:0] CID_BASE = 6'd0,
    parameter logic [3:0] HOLD_MAX = 4'd8
) (
    input logic               clk,
    input logic               rst,
    cache_bus_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;

    state_t              state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       rr_ptr;
    logic [3:0]          hold_cnt;
    logic [IW-1:0]       pick;
    logic                pick_vld;
    logic [IW-1:0]       idx;
    fta_cmd_request256_t own_req;
    logic                accept;
    logic [3:0]          hold_nxt;
    logic [NREQ-1:0]     ack_vec;
    logic                bad_ack;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        own_req  = bus.req_i[owner];
        accept   = ((state == GRANT) || (state == HOLD)) && own_req.cyc && !bus.bus_full_i;
        hold_nxt = sat_inc(hold_cnt);
    end

`ifdef CACHE_BUS_ARB_PRI_EN
    logic [3:0] best_pri;
    logic [3:0] owner_pri;
    logic       preempt;

    // Highest pri wins; strict compare keeps the earliest round-robin candidate on ties.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        best_pri = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_i[idx].cyc && (!pick_vld || bus.req_i[idx].pri > best_pri)) begin
                pick     = idx;
                pick_vld = 1'b1;
                best_pri = bus.req_i[idx].pri;
            end
        end
    end

    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if ((IW'(i) != owner) && bus.req_i[i].cyc && (bus.req_i[i].pri > owner_pri))
                preempt = 1'b1;
        end
    end
`else
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_i[idx].cyc && !pick_vld) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end
`endif

    // Stall only the current owner on bus_full; everyone else waits for a grant.
    always_comb begin
        bus.full_o = '1;
        if ((state == GRANT) || (state == HOLD))
            bus.full_o[owner] = bus.bus_full_i;
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.resp_cid_i == CID_BASE + 6'(i))
                ack_vec[i] = bus.resp_ack_i;
        end
        bad_ack = bus.resp_ack_i && (ack_vec == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            hold_cnt      <= '0;
            bus.grant_o   <= '0;
            bus.bus_req_o <= '0;
            bus.ack_o     <= '0;
            bus.bad_ack_o <= 1'b0;
`ifdef CACHE_BUS_ARB_PRI_EN
            owner_pri     <= '0;
`endif
        end else begin
            bus.ack_o     <= ack_vec;
            bus.bad_ack_o <= bad_ack;

            if (accept) begin
                bus.bus_req_o <= own_req;
            end else begin
                bus.bus_req_o.cyc <= 1'b0;
                bus.bus_req_o.sel <= '0;
                bus.bus_req_o.cti <= CTI_CLASSIC;
            end
`ifdef CACHE_BUS_ARB_PRI_EN
            if (accept)
                owner_pri <= own_req.pri;
`endif

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner       <= pick;
                        bus.grant_o <= onehot(pick);
                        state       <= GRANT;
`ifdef CACHE_BUS_ARB_PRI_EN
                        owner_pri   <= bus.req_i[pick].pri;
`endif
                    end
                end
                GRANT: begin
                    if (!own_req.cyc) begin
                        if (bus.lock_i[owner]) begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            bus.grant_o <= '0;
                            state       <= RELEASE;
                        end
                    end
                end
                HOLD: begin
                    // The grant plus HOLD cycles add up to HOLD_MAX idle cycles before release.
                    if (own_req.cyc) begin
                        state <= GRANT;
                    end else if (!bus.lock_i[owner] || (hold_nxt >= HOLD_MAX - 4'd1)
`ifdef CACHE_BUS_ARB_PRI_EN
                                 || preempt
`endif
                                 ) begin
                        bus.grant_o <= '0;
                        state       <= RELEASE;
                    end else begin
                        hold_cnt <= hold_nxt;
                    end
                end
                RELEASE: begin
                    rr_ptr <= next_idx(owner);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter with NREQ=4, CID_BASE=0, HOLD_MAX=8.
module tb_cache_bus_arbiter;
    import fta_bus_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    cache_bus_arbiter_if #(.NREQ(4)) bus_if ();

    cache_bus_arbiter #(.NREQ(4), .CID_BASE(6'd0), .HOLD_MAX(4'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) bus_if.req_i[i] = '0;
        bus_if.lock_i     = '0;
        bus_if.bus_full_i = 1'b0;
        bus_if.resp_ack_i = 1'b0;
        bus_if.resp_cid_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] adr, input logic [3:0] pri);
        bus_if.req_i[i].cyc = 1'b1;
        bus_if.req_i[i].adr = adr;
        bus_if.req_i[i].sel = 32'hFFFF_FFFF;
        bus_if.req_i[i].cti = CTI_INCR;
        bus_if.req_i[i].pri = pri;
        bus_if.req_i[i].tid.channel = 6'(i);
    endtask

    initial begin
        logic [3:0] exp_g;
        logic       seen;
        logic       bad_seen;
        logic [3:0] rot [5];
        n_chk  = 0;
        n_fail = 0;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

        // Reset values while reset is asserted
        rst = 1'b1;
        clear_inputs();
        tick();
        chk("reset_grant", bus_if.grant_o, 4'b0000);
        chk("reset_full", bus_if.full_o, 4'b1111);
        chk("reset_bus_cyc", bus_if.bus_req_o.cyc, 1'b0);
        chk("reset_bus_sel", bus_if.bus_req_o.sel, 32'h0);
        chk("reset_ack", {bus_if.bad_ack_o, bus_if.ack_o}, 5'b0);
        tick();
        rst = 1'b0;

        // Priority vs round robin from IDLE with rr_ptr=0
        set_req(0, 32'h0000_4000, 4'd7);
        set_req(3, 32'h0000_4800, 4'd9);
        tick();
`ifdef CACHE_BUS_ARB_PRI_EN
        exp_g = 4'b1000;
`else
        exp_g = 4'b0001;
`endif
        chk("pri_first_grant", bus_if.grant_o, exp_g);

        // Single requester, locked line pair
        do_reset();
        set_req(0, 32'h0000_1000, 4'd0);
        bus_if.lock_i[0] = 1'b1;
        tick();
        chk("single_grant", bus_if.grant_o, 4'b0001);
        chk("single_no_fwd_on_select", bus_if.bus_req_o.cyc, 1'b0);
        chk("single_full_owner", bus_if.full_o, 4'b1110);
        tick();
        chk("single_cyc0", bus_if.bus_req_o.cyc, 1'b1);
        chk("single_adr0", bus_if.bus_req_o.adr, 32'h0000_1000);
        bus_if.req_i[0].adr = 32'h0000_1020;
        tick();
        chk("single_cyc1", bus_if.bus_req_o.cyc, 1'b1);
        chk("single_adr1", bus_if.bus_req_o.adr, 32'h0000_1020);
        chk("single_grant_kept", bus_if.grant_o, 4'b0001);
        bus_if.req_i[0].cyc = 1'b0;
        tick();
        chk("single_idle_cyc", bus_if.bus_req_o.cyc, 1'b0);
        chk("single_idle_cti", bus_if.bus_req_o.cti, CTI_CLASSIC);
        chk("single_idle_adr_held", bus_if.bus_req_o.adr, 32'h0000_1020);

        // Lock window expiry for owner 1, then requester 2 takes over
        do_reset();
        set_req(1, 32'h0000_2000, 4'd0);
        bus_if.lock_i[1] = 1'b1;
        tick();
        chk("hold_grant1", bus_if.grant_o, 4'b0010);
        set_req(2, 32'h0000_2800, 4'd0);
        tick();
        chk("hold_waiter_full", bus_if.full_o[2], 1'b1);
        bus_if.req_i[1].cyc = 1'b0;
        bad_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.grant_o !== 4'b0010) bad_seen = 1'b1;
            tick();
        end
        chk("hold_kept_8_idle", bad_seen, 1'b0);
        chk("hold_released", bus_if.grant_o, 4'b0000);
        tick();
        tick();
        chk("hold_next_grant2", bus_if.grant_o, 4'b0100);

        // Round robin with all four requesting, no lock
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'h0000_5000 + 32'(i * 32), 4'd0);
        for (int n = 0; n < 5; n++) begin
            seen = 1'b0;
            for (int w = 0; w < 10 && !seen; w++) begin
                tick();
                if (bus_if.grant_o != 4'b0000) seen = 1'b1;
            end
            chk("rr_grant_seen", seen, 1'b1);
            chk("rr_grant", bus_if.grant_o, rot[n]);
            for (int i = 0; i < 4; i++)
                if (rot[n][i]) begin
                    tick();
                    bus_if.req_i[i].cyc = 1'b0;
                    tick();
                    chk("rr_release_gap", bus_if.grant_o, 4'b0000);
                    bus_if.req_i[i].cyc = 1'b1;
                end
        end

        // Long downstream stall on owner 0
        do_reset();
        bus_if.bus_full_i = 1'b1;
        set_req(0, 32'h0000_3000, 4'd0);
        tick();
        chk("stall_grant", bus_if.grant_o, 4'b0001);
        bad_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.full_o[0] !== 1'b1 || bus_if.bus_req_o.cyc !== 1'b0 ||
                bus_if.grant_o !== 4'b0001) bad_seen = 1'b1;
            tick();
        end
        chk("stall_held_20", bad_seen, 1'b0);
        bus_if.bus_full_i = 1'b0;
        #1;
        chk("stall_full_drop", bus_if.full_o, 4'b1110);
        tick();
        chk("stall_fwd_cyc", bus_if.bus_req_o.cyc, 1'b1);
        chk("stall_fwd_adr", bus_if.bus_req_o.adr, 32'h0000_3000);

        // Asynchronous reset mid-transfer
        rst = 1'b1;
        #1;
        chk("midrst_grant", bus_if.grant_o, 4'b0000);
        chk("midrst_cyc", bus_if.bus_req_o.cyc, 1'b0);
        chk("midrst_full", bus_if.full_o, 4'b1111);
        tick();
        rst = 1'b0;
        clear_inputs();

        // Ack routing by channel id
        tick();
        bus_if.resp_ack_i = 1'b1;
        bus_if.resp_cid_i = 6'd2;
        tick();
        chk("ack_cid2", {bus_if.bad_ack_o, bus_if.ack_o}, 5'b0_0100);
        bus_if.resp_cid_i = 6'd9;
        tick();
        chk("ack_cid9_bad", {bus_if.bad_ack_o, bus_if.ack_o}, 5'b1_0000);
        bus_if.resp_ack_i = 1'b0;
        tick();
        chk("ack_pulse_end", {bus_if.bad_ack_o, bus_if.ack_o}, 5'b0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one FTA 256-bit command request port between NREQ cache request generators: I-cache and D-cache miss generators plus a prefetcher.
- Round-robin arbitration with a lock window, so a generator's back-to-back line requests (two 32-byte halves) stay contiguous.
- Routes bus acks back to the owning generator by channel id.
- Sits between the per-cache request generators and the core's bus interface unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CID_BASE, 6'd0, channel id of requester 0; requester i owns channel CID_BASE+i.
- HOLD_MAX, 4'd8, maximum idle cycles a locked grant is held with no cyc before forced release.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_i  input  NREQ x fta_cmd_request256_t  request from each generator; valid when .cyc=1.
- lock_i  input  NREQ  requester wants to keep its grant between pulses.
- full_o  output  NREQ  per-requester stall, same meaning as a bus full input to a generator.
- grant_o  output  NREQ  one-hot current owner, all zero when idle.
- bus_req_o  output  fta_cmd_request256_t  registered request to the bus interface unit.
- bus_full_i  input  1  downstream cannot accept.
- resp_ack_i  input  1  response ack from the bus.
- resp_cid_i  input  6  channel id of the acked transaction (tid.channel).
- ack_o  output  NREQ  per-requester ack pulse.
- bad_ack_o  output  1  pulse: ack with a channel id that no requester owns.

Behaviour:
- Reset (async), all outputs and state:
  - state=IDLE, grant_o=0, full_o=all ones, bus_req_o='0 (cyc=0, sel=0, cti=CLASSIC).
  - ack_o=0, bad_ack_o=0, rr_ptr=0, hold_cnt=0.
- States:
  - IDLE: no owner. Pick the first requester with req_i[i].cyc, searching from rr_ptr upward modulo NREQ. Set grant_o one-hot and go to GRANT next cycle. No request is forwarded in the selection cycle.
  - GRANT, owner g:
    - full_o[g] = bus_full_i; all other full_o bits = 1.
    - Accept when req_i[g].cyc & !bus_full_i. On the next edge, bus_req_o <= req_i[g] (1-cycle latency).
    - When no acceptance occurs, bus_req_o.cyc <= 0, sel <= 0 and cti <= CLASSIC; other fields are held.
    - Cycle with no cyc from g: if lock_i[g]=1, go to HOLD with hold_cnt=0; otherwise RELEASE.
  - HOLD: grant kept, behaving as GRANT.
    - req_i[g].cyc seen: accept per the GRANT rule, return to GRANT.
    - lock_i[g] drops, or hold_cnt reaches HOLD_MAX-1: RELEASE.
    - hold_cnt increments each idle cycle and saturates.
  - RELEASE: one cycle. grant_o=0, rr_ptr <= g+1 mod NREQ, then IDLE.
- Arbitration fairness: after release, the previous owner has lowest priority. With all NREQ requesting continuously, each is granted once per NREQ grant periods.
- full_o is combinational from state and bus_full_i. Every other output is registered.
- Ack routing:
  - ack_o[i] pulses one cycle after resp_ack_i when resp_cid_i == CID_BASE+i.
  - No owner for the id: bad_ack_o pulses and no ack_o fires.
  - Acks are independent of the grant state; they are never blocked.
- Simultaneous events:
  - Ack and acceptance in the same cycle are both processed.
  - A requester whose cyc rises while another holds the grant sees full_o=1 until it is granted.
- bus_full_i high for many cycles: the grant stays with g. Stall cycles do not count toward hold_cnt and do not release the grant.
- Reset mid-transfer: everything returns to reset values immediately. The partially issued pair is not replayed, because the generators are reset alongside.

Optional Feature:
- Macro: CACHE_BUS_ARB_PRI_EN.
- Defined: IDLE selection picks the requesting input with the highest req_i[i].pri. Ties are broken by round-robin from rr_ptr. A grant held in HOLD is released early, in the next cycle, if another requester presents a strictly higher pri.
- Undefined: pri is ignored for arbitration and passed through unchanged. Pure round-robin as above.

Test Plan:
- Single requester, NREQ=4: req_i[0].cyc pulses two adr values 0x1000/0x1020 with lock_i[0]=1, bus_full_i=0.
  - grant_o=0001 one cycle after the first cyc.
  - bus_req_o.cyc=1 with adr 0x1000 on the following cycle, then 0x1020; no other grant in between.
- All four requesting continuously, lock=0: grants rotate 0001, 0010, 0100, 1000, 0001, each separated by one RELEASE cycle.
- Owner 1 locked and idle, HOLD_MAX=8: grant released exactly 8 idle cycles after the last cyc; requester 2 is granted next.
- bus_full_i held high 20 cycles while owner 0 requests:
  - full_o[0]=1 and bus_req_o.cyc=0 throughout; grant unchanged.
  - Request forwarded one cycle after bus_full_i falls.
- resp_ack_i with resp_cid_i=2 gives ack_o=0100 one cycle later. resp_cid_i=9 gives bad_ack_o=1 and ack_o=0.
- With CACHE_BUS_ARB_PRI_EN: requesters 0 (pri 7) and 3 (pri 9) request simultaneously from IDLE, so 3 is granted first. Rerun with the macro undefined and rr_ptr=0: 0 is granted first.
